ser_par_align: RTL

- Parametrised successor of the fixed 8-bit serial-to-parallel converter.
- Runs from the single bit clock `clk_32f`; no external word clock is required.
- Hunts for the comma word at any bit offset and derives word alignment internally.
- Asserts `active` after LOCK_COUNT consecutive aligned commas, then emits parallel data words with valid/strobe. It drops lock on repeated misaligned commas.
- Sits in the receive path after the serial line, feeding the byte-wide receive logic.

---
 rtl/ser_par_align.sv | 117 +++++++++++
 1 files changed

// File: rtl/ser_par_align.sv
// ser_par_align: serial-to-parallel converter with comma hunt, verify and lock tracking.
// Define SER_PAR_STATS_EN to add the lock_loss_cnt / word_cnt statistics ports.
module ser_par_align #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] COMMA        = 8'hBC,
   parameter int               LOCK_COUNT   = 4,
   parameter int               UNLOCK_COUNT = 2
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             word_strobe,
`ifdef SER_PAR_STATS_EN
   output logic             active,
   output logic [7:0]       lock_loss_cnt,
   output logic [15:0]      word_cnt
`else
   output logic             active
`endif
);
   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(UNLOCK_COUNT + 1);
   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
   state_t state, state_d;
   logic [WIDTH-1:0] sr, sr_next, data_d;
   logic [BW-1:0] bit_cnt, bit_cnt_d;
   logic [CW-1:0] comma_cnt, comma_cnt_d;
   logic [MW-1:0] miss_cnt, miss_cnt_d;
   logic valid_d, strobe_d, active_d, is_comma, boundary;
   assign sr_next  = {sr[WIDTH-2:0], data_in};
   assign is_comma = sr_next == COMMA;
   assign boundary = bit_cnt == BW'(WIDTH - 1);
   always_comb begin
      state_d     = state;
      bit_cnt_d   = boundary ? '0 : bit_cnt + BW'(1);
      comma_cnt_d = comma_cnt;
      miss_cnt_d  = miss_cnt;
      data_d      = data_out;
      valid_d     = valid_out;
      strobe_d    = 1'b0;
      active_d    = active;
      case (state)
         HUNT: if (is_comma) begin
            bit_cnt_d   = '0;
            comma_cnt_d = CW'(1);
            state_d     = LOCK_COUNT == 1 ? LOCKED : VERIFY;
            active_d    = LOCK_COUNT == 1;
         end
         VERIFY: if (boundary) begin
            if (is_comma) begin
               comma_cnt_d = comma_cnt + CW'(1);
               if (comma_cnt_d == CW'(LOCK_COUNT)) begin
                  state_d  = LOCKED;
                  active_d = 1'b1;
               end
            end else begin
               comma_cnt_d = '0;
               state_d     = HUNT;
            end
         end
         LOCKED: if (boundary) begin
            data_d   = sr_next;
            strobe_d = 1'b1;
            valid_d  = !is_comma;
            if (is_comma) miss_cnt_d = '0;
         end else if (is_comma) begin
            // a comma off the word grid means the sender slipped
            miss_cnt_d = miss_cnt + MW'(1);
            if (miss_cnt_d == MW'(UNLOCK_COUNT)) begin
               state_d     = HUNT;
               active_d    = 1'b0;
               valid_d     = 1'b0;
               miss_cnt_d  = '0;
               comma_cnt_d = '0;
            end
         end
         default: state_d = HUNT;
      endcase
   end
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state       <= HUNT;
         sr          <= '0;
         bit_cnt     <= '0;
         comma_cnt   <= '0;
         miss_cnt    <= '0;
         data_out    <= '0;
         valid_out   <= 1'b0;
         word_strobe <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= state_d;
         sr          <= sr_next;
         bit_cnt     <= bit_cnt_d;
         comma_cnt   <= comma_cnt_d;
         miss_cnt    <= miss_cnt_d;
         data_out    <= data_d;
         valid_out   <= valid_d;
         word_strobe <= strobe_d;
         active      <= active_d;
      end
   end
`ifdef SER_PAR_STATS_EN
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         lock_loss_cnt <= '0;
         word_cnt      <= '0;
      end else begin
         if (state == LOCKED && state_d == HUNT && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
         if (strobe_d && valid_d) word_cnt <= word_cnt + 16'd1;
      end
   end
`endif
endmodule
